// File: rtl/fft_seq_pkg.sv
// fft_frame_sequencer shared types.
// State encoding is exported for the status register.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG      = 3'd1,
    CFG_WAIT = 3'd2,
    IN_TRIG  = 3'd3,
    IN_WAIT  = 3'd4,
    OUT_WAIT = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_t;

  function automatic logic is_wait(state_t s);
    return s inside {CFG_WAIT, IN_WAIT, OUT_WAIT};
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Control/status bundle between the frame sequencer
// and the axi_fft register wrapper.
interface fft_frame_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic start;
  logic abort;
  logic continuous;
  logic cfg_dirty;
  logic cfg_tvalid;
  logic cfg_tready;
  logic in_streaming;
  logic out_receiving;
  logic irq_clr;
  logic cfg_commit;
  logic in_trig;
  logic busy;
  logic done;
  logic irq;
  logic timeout;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [2:0] state;

  modport master (
    input  start, abort, continuous, cfg_dirty,
    input  cfg_tvalid, cfg_tready,
    input  in_streaming, out_receiving, irq_clr,
    output cfg_commit, in_trig, busy, done,
    output irq, timeout, frame_count, state
  );

  modport slave (
    output start, abort, continuous, cfg_dirty,
    output cfg_tvalid, cfg_tready,
    output in_streaming, out_receiving, irq_clr,
    input  cfg_commit, in_trig, busy, done,
    input  irq, timeout, frame_count, state
  );
endinterface

// File: rtl/fft_seq_watchdog.sv
// Per-phase watchdog: counts enabled cycles,
// expires on the cycle the count hits the limit.
module fft_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = en && !clr && (cnt == LIM);
endmodule

// File: rtl/fft_frame_sequencer.sv
// Runs one FFT frame: config commit, input stream,
// output capture, done/IRQ; optional back-to-back.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input logic clk,
  input logic resetn,
  fft_frame_sequencer_if.master bus
);
  state_t st;
  logic in_seen;
  logic out_seen;
  logic irq_r;
  logic to_r;
  logic [CNT_WIDTH-1:0] fc;
  logic wait_st;
  logic leave;
  logic wd_clr;
  logic wd_exp;

  assign wait_st = is_wait(st);

  assign leave =
    (st == CFG_WAIT && bus.cfg_tvalid && bus.cfg_tready) ||
    (st == IN_WAIT && in_seen && !bus.in_streaming) ||
    (st == OUT_WAIT && out_seen && !bus.out_receiving);

  // Any state change restarts the phase timer.
  assign wd_clr = !wait_st || leave || bus.abort;

  fft_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .resetn (resetn),
    .clr    (wd_clr),
    .en     (wait_st),
    .expire (wd_exp)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_seen  <= 1'b0;
      out_seen <= 1'b0;
    end else if (st == IN_TRIG) begin
      in_seen  <= 1'b0;
      out_seen <= 1'b0;
    end else begin
      if (st == IN_WAIT && bus.in_streaming)
        in_seen <= 1'b1;
      if ((st == IN_WAIT || st == OUT_WAIT) &&
          bus.out_receiving)
        out_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st    <= IDLE;
      fc    <= '0;
      irq_r <= 1'b0;
      to_r  <= 1'b0;
    end else begin
      if (bus.irq_clr)
        irq_r <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            st   <= bus.cfg_dirty ? CFG : IN_TRIG;
            to_r <= 1'b0;
          end
        end
        CFG:      st <= CFG_WAIT;
        CFG_WAIT: if (leave) st <= IN_TRIG;
        IN_TRIG:  st <= IN_WAIT;
        IN_WAIT:  if (leave) st <= OUT_WAIT;
        OUT_WAIT: if (leave) st <= DONE;
        DONE: begin
          fc    <= fc + CNT_WIDTH'(1);
          irq_r <= 1'b1;
          if (bus.continuous && !bus.abort)
            st <= bus.cfg_dirty ? CFG : IN_TRIG;
          else
            st <= IDLE;
        end
        ERR: ;
      endcase
      if (wd_exp) begin
        st    <= ERR;
        to_r  <= 1'b1;
        irq_r <= 1'b1;
      end
      if (bus.abort && st != IDLE && st != DONE)
        st <= IDLE;
    end
  end

  assign bus.cfg_commit  = (st == CFG);
  assign bus.in_trig     = (st == IN_TRIG);
  assign bus.done        = (st == DONE);
  assign bus.busy        = (st != IDLE);
  assign bus.irq         = irq_r;
  assign bus.timeout     = to_r;
  assign bus.frame_count = fc;
  assign bus.state       = st;
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Hardware controller that runs one complete FFT frame without CPU polling: optional config commit, input-buffer streaming, output-buffer capture, then completion and IRQ. It sits beside the FFT data-input, data-output and config blocks in the axi_fft register wrapper. It drives their commit/trigger pulses and monitors their status. Supports single-shot and continuous (back-to-back frame) operation, a per-phase watchdog and a frame counter.

Parameters:
TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles per wait phase (>=2)
CNT_WIDTH, 16, frame counter width

Ports:
clk  in  1  core clock (same as up_clk)
resetn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to run a frame; honoured only in IDLE
abort  in  1  one-cycle request to abandon the current sequence
continuous  in  1  level; at frame end, re-run without a new start
cfg_dirty  in  1  level; config register changed since last commit
cfg_tvalid  in  1  monitor of config AXIS tvalid
cfg_tready  in  1  monitor of config AXIS tready
in_streaming  in  1  data-input block streaming status
out_receiving  in  1  data-output block receiving status
irq_clr  in  1  one-cycle IRQ clear
cfg_commit  out  1  one-cycle pulse to config block
in_trig  out  1  one-cycle pulse to data-input block
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on frame completion
irq  out  1  sticky; set on done or timeout
timeout  out  1  sticky watchdog error flag
frame_count  out  CNT_WIDTH  completed frames, wraps
state  out  3  current state encoding, for status register

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; frame_count=0; internal flags and watchdog cleared.
- Registered FSM. cfg_commit=(state==CFG), in_trig=(state==IN_TRIG), done=(state==DONE). Each is exactly one cycle.
- IDLE: start && cfg_dirty -> CFG; start && !cfg_dirty -> IN_TRIG. First pulse appears the cycle after start. Entering from IDLE clears timeout.
- CFG (1 cycle) -> CFG_WAIT. Exit CFG_WAIT on the cycle with cfg_tvalid && cfg_tready -> IN_TRIG.
- IN_TRIG (1 cycle) -> IN_WAIT. Clear in_seen and out_seen on entry.
- IN_WAIT: set in_seen while in_streaming=1. Exit when in_seen && !in_streaming -> OUT_WAIT. Also set out_seen while out_receiving=1, so early FFT output is not missed.
- OUT_WAIT: set out_seen while out_receiving=1. Exit when out_seen && !out_receiving -> DONE.
- DONE (1 cycle): frame_count+1 (wraps at 2^CNT_WIDTH); set irq.
  - continuous && !abort -> CFG if cfg_dirty, else IN_TRIG.
  - otherwise -> IDLE.
- Watchdog: counter cleared on every state change. Increments in CFG_WAIT, IN_WAIT and OUT_WAIT. Reaching TIMEOUT_CYCLES-1 -> ERR, timeout=1, irq=1.
- ERR: holds; start ignored; abort -> IDLE. timeout stays set until the next accepted start.
- abort in any state except IDLE and DONE -> IDLE next cycle; no done, no counter change, irq unchanged. abort in DONE suppresses continuous re-run.
- abort and start in the same cycle in IDLE: abort wins, stay IDLE.
- start outside IDLE: ignored.
- irq_clr clears irq. If a set and irq_clr coincide, the set wins.
- Asynchronous reset mid-frame returns to IDLE immediately. Downstream blocks are reset by their own resetn.

Decomposition:
- Shared package fft_seq_pkg holds the state localparams: IDLE=0, CFG=1, CFG_WAIT=2, IN_TRIG=3, IN_WAIT=4, OUT_WAIT=5, DONE=6, ERR=7.
- Natural sub-module fft_seq_watchdog: a clear/enable counter with an expire output, parameterised by TIMEOUT_CYCLES.
- FSM, flags and frame counter stay in the top.

Test Plan:
1. cfg_dirty=1; start; handshake 3 cycles later; in_streaming high 16 cycles; out_receiving high 16 cycles.
   Required: cfg_commit at cycle 1, in_trig once, done once, frame_count=1, irq=1.
2. cfg_dirty=0; start.
   Required: no cfg_commit; in_trig the cycle after start; otherwise as scenario 1.
3. continuous=1; cfg_dirty=0; 3 frames driven.
   Required: in_trig the cycle after each done, frame_count=3. Drop continuous during frame 3 -> IDLE after done.
4. TIMEOUT_CYCLES=8; in_streaming never rises.
   Required: ERR after 8 cycles in IN_WAIT, timeout=1, irq=1. start ignored. abort -> IDLE. Next start clears timeout.
5. abort during OUT_WAIT.
   Required: IDLE next cycle, done never pulses, frame_count unchanged. Then irq_clr coinciding with a done: irq remains 1.
6. out_receiving pulses during IN_WAIT.
   Required: out_seen retained, DONE reached as soon as in_streaming falls and out_receiving is low. Assert resetn low mid-frame: all outputs 0 asynchronously.
